// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures period/high time of a divided clock, flags lock and stall
// Define CLK_MON_SYNC_EN to pass div_clk_i through a 2-flop synchronizer first.
module clk_div_monitor #(
  parameter int CNT_W      = 10,
  parameter int MAX_PERIOD = 1023
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             div_clk_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             timeout_o
);

  typedef enum logic {ST_IDLE, ST_MEAS} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             s_in;
  logic             s_q;
  logic             s_prev_q;
  logic             rise;
  logic             have_prev_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic             do_clear, do_start, do_meas, do_timeout;

`ifdef CLK_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], div_clk_i};
  end

  assign s_in = sync_q[1];
`else
  assign s_in = div_clk_i;
`endif

  // Both sample flops reset high so a clock already high at release is not a rise.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      s_q      <= s_in;
      s_prev_q <= s_q;
    end
  end

  assign rise = s_q & ~s_prev_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    do_clear   = 1'b0;
    do_start   = 1'b0;
    do_meas    = 1'b0;
    do_timeout = 1'b0;
    if (clear_i) begin
      state_d  = ST_IDLE;
      do_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d  = ST_MEAS;
            do_start = 1'b1;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            do_meas = 1'b1;
          end else if (period_cnt_q == MAX_CNT) begin
            state_d    = ST_IDLE;
            do_timeout = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Lock compares against the previous result before period_o/high_o are overwritten.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      have_prev_q  <= 1'b0;
      period_o     <= '0;
      high_o       <= '0;
      meas_valid_o <= 1'b0;
      locked_o     <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;
      if (do_clear) begin
        period_cnt_q <= '0;
        high_cnt_q   <= '0;
        have_prev_q  <= 1'b0;
        locked_o     <= 1'b0;
        timeout_o    <= 1'b0;
      end else if (do_start) begin
        period_cnt_q <= CNT_ONE;
        high_cnt_q   <= CNT_ONE;
      end else if (do_meas) begin
        period_o     <= period_cnt_q;
        high_o       <= high_cnt_q;
        meas_valid_o <= 1'b1;
        timeout_o    <= 1'b0;
        locked_o     <= have_prev_q & (period_cnt_q == period_o) & (high_cnt_q == high_o);
        have_prev_q  <= 1'b1;
        period_cnt_q <= CNT_ONE;
        high_cnt_q   <= CNT_ONE;
      end else if (do_timeout) begin
        period_cnt_q <= '0;
        high_cnt_q   <= '0;
        have_prev_q  <= 1'b0;
        locked_o     <= 1'b0;
        timeout_o    <= 1'b1;
      end else if (state_q == ST_MEAS) begin
        period_cnt_q <= period_cnt_q + CNT_ONE;
        high_cnt_q   <= high_cnt_q + {{(CNT_W-1){1'b0}}, s_q};
      end
    end
  end

endmodule
